axis_digit_scheduler: RTL and testbench
=======================================

Name: axis_digit_scheduler

Overview:
- Sequences the post-processing of one accelerometer sample (X, Y, Z) through a single shared sequential divider.
- Per axis: take the absolute value, scale it by 1/10, saturate it to 99, then split it into tens and ones for the seven-segment drivers.
- Sits between the SPI-control sample outputs (gated by the refresh tick) and the seg7 instances.
- Replaces six combinational dividers with one time-multiplexed unit. All three axes' results commit atomically.

Parameters:
- DATA_W, 16, width of the signed two's-complement axis samples.
- DIVISOR, 10, first-stage scale divisor.
- SAT_MAX, 99, largest scaled value shown on two digits.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- sample_valid  in  1  one-cycle request to process data_x/y/z.
- data_x  in  DATA_W  signed X sample.
- data_y  in  DATA_W  signed Y sample.
- data_z  in  DATA_W  signed Z sample.
- scaled_x, scaled_y, scaled_z  out  8 each  saturated |data|/DIVISOR.
- tens_x, tens_y, tens_z  out  4 each  tens digit of scaled value.
- ones_x, ones_y, ones_z  out  4 each  ones digit of scaled value.
- neg_x, neg_y, neg_z  out  1 each  sign bit of the processed sample.
- sat_x, sat_y, sat_z  out  1 each  high if the scaled value was clipped to SAT_MAX.
- busy  out  1  scheduler processing a sample.
- done  out  1  one-cycle pulse when all outputs are updated.
- overrun  out  1  one-cycle pulse when sample_valid is dropped.

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; snapshot and working registers are cleared. Reset asserted mid-operation aborts with no done pulse, and the outputs return to 0.
- Acceptance:
  - In IDLE, sample_valid=1 captures data_x/y/z into the snapshot at that edge (the acceptance edge).
  - busy=1 from the next cycle until the cycle done is high, inclusive.
  - Inputs may change after acceptance without effect.
- sample_valid while busy (including the done cycle): the request is ignored; overrun pulses 1 cycle in the following cycle; the current operation is unaffected.
- FSM states: IDLE, LOAD, DIV1, DIV2, STORE, COMMIT. Per axis, visited in fixed order X, Y, Z:
  - LOAD (1 cycle): abs = sign ? (~s + 1) : s, held at DATA_W bits (-32768 gives 32768 unsigned). Record the sign.
  - DIV1 (DATA_W = 16 cycles): restoring division abs / DIVISOR. If quotient > SAT_MAX, q = SAT_MAX and sat = 1; otherwise q = quotient[7:0] and sat = 0.
  - DIV2 (8 cycles): same divider computes q / 10; quotient is tens, remainder is ones.
  - STORE (1 cycle): q, tens, ones, sign and sat go into that axis's shadow registers. Then go to LOAD of the next axis, or to COMMIT after Z.
  - COMMIT (1 cycle): all shadow registers copy to the outputs simultaneously; done=1; next state IDLE.
- Latency: acceptance edge E; outputs and done visible after edge E+79 (3 × 26 + 1); done lasts exactly 1 cycle.
- A new sample can be accepted in the cycle after done (IDLE). Back-to-back throughput is 1 sample per 80 cycles.
- Outputs hold their values between commits. Digits are always in 0..9, and tens ≤ 9 because of the saturation.
- The divider is never started while running. The FSM owns its start/operand/divisor mux; there is no other requester.

Decomposition:
- Shared package accel_pkg holds:
  - constants DATA_W, DIVISOR, SAT_MAX, DIV1_CYCLES = 16, DIV2_CYCLES = 8;
  - typedef of the FSM state enum;
  - axis index enum (AX_X, AX_Y, AX_Z).
- One sub-module, seq_divider:
  - parameter WIDTH;
  - ports clk, rst, start, dividend, divisor;
  - outputs quotient, remainder, valid;
  - restoring, one bit per cycle.
- It is instanced once and reused for both division stages of all axes.

Test Plan:
- x=0x00B4, y=0xFF4C, z=0x0009, one sample_valid pulse → after 79 cycles done=1 for 1 cycle. Expected X: scaled=18, tens=1, ones=8, neg=0. Expected Y: scaled=18, tens=1, ones=8, neg=1. Expected Z: scaled=0, tens=0, ones=0. All sat=0.
- z=0x8000, x=0x03E7 (999) → Z: scaled=99, tens=9, ones=9, sat=1. X: scaled=99, sat=0.
- sample_valid at acceptance+10 and again during the done cycle → overrun pulses twice; results equal the first sample; busy stays high through done.
- Samples change every cycle after acceptance → outputs reflect only the snapshot taken at the acceptance edge.
- rst asserted at acceptance+40 → all outputs 0, busy=0, no done. A fresh sample after reset completes normally in 79 cycles.
- Two samples accepted 80 cycles apart (x=50 then x=-7) → first commit scaled_x=5; second commit scaled_x=0, neg_x=1. Outputs stay at 5 in between.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared constants and types for the accelerometer digit scheduler.
//   DATA_W       width of the signed axis samples
//   DIVISOR      first-stage scale divisor
//   SAT_MAX      largest scaled value that fits on two seven-segment digits
//   DIV1_CYCLES  iterations of the first (scale) division
//   DIV2_CYCLES  iterations of the second (tens/ones) division
package accel_pkg;

  localparam int DATA_W      = 16;
  localparam int DIVISOR     = 10;
  localparam int SAT_MAX     = 99;
  localparam int DIV1_CYCLES = 16;
  localparam int DIV2_CYCLES = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DIV1   = 3'd2,
    ST_DIV2   = 3'd3,
    ST_STORE  = 3'd4,
    ST_COMMIT = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    AX_X = 2'd0,
    AX_Y = 2'd1,
    AX_Z = 2'd2
  } axis_e;

  // Everything shown for one axis.
  typedef struct packed {
    logic [7:0] scaled;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       neg;
    logic       sat;
  } digits_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring sequential divider, one quotient bit per clock.
//   clk, rst          clock and asynchronous active-high reset
//   start             load operands; the first iteration happens on this edge
//   nbits             number of iterations to run (1..WIDTH)
//   dividend, divisor unsigned operands
//   quotient          quotient bits accumulate in the low nbits bits
//   remainder         remainder of the processed bits
//   valid             one-cycle pulse once the last iteration has landed
// Bits are consumed MSB first, so a run shorter than WIDTH divides the top
// nbits bits of the dividend: callers left-align short operands.
module seq_divider #(
  parameter int WIDTH = 16,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW-1:0]    nbits,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] src_quo;
  logic [WIDTH-1:0] src_rem;
  logic [WIDTH-1:0] src_div;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   trial_sub;
  logic             step_ge;

  // One restoring step on either fresh operands (start) or the running state.
  always_comb begin
    src_quo   = start ? dividend : quo_q;
    src_rem   = start ? {WIDTH{1'b0}} : rem_q;
    src_div   = start ? divisor : div_q;
    trial     = {src_rem, src_quo[WIDTH-1]};
    step_ge   = (trial >= {1'b0, src_div});
    trial_sub = trial - {1'b0, src_div};

    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;

    if (start) begin
      quo_d   = {src_quo[WIDTH-2:0], step_ge};
      rem_d   = step_ge ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
      div_d   = divisor;
      cnt_d   = nbits - CW'(1);
      valid_d = (nbits == CW'(1));
    end else if (cnt_q != {CW{1'b0}}) begin
      quo_d   = {src_quo[WIDTH-2:0], step_ge};
      rem_d   = step_ge ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
      cnt_d   = cnt_q - CW'(1);
      valid_d = (cnt_q == CW'(1));
    end else begin
      quo_d = quo_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q   <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      div_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      valid_q <= 1'b0;
    end else begin
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign valid     = valid_q;

endmodule

// File: rtl/axis_digit_scheduler.sv
// Turns one X/Y/Z accelerometer sample into saturated two-digit values for
// the seven-segment drivers, using a single shared sequential divider.
//   clk, rst              clock and asynchronous active-high reset
//   sample_valid          one-cycle request to process data_x/y/z
//   data_x/y/z            signed samples, snapshotted on acceptance
//   scaled_*              min(|data|/DIVISOR, SAT_MAX)
//   tens_*, ones_*        decimal digits of scaled_*
//   neg_*, sat_*          sample sign and saturation flag
//   busy                  high from the cycle after acceptance through done
//   done                  one-cycle pulse when all three axes update together
//   overrun               one-cycle pulse after a request that was ignored
module axis_digit_scheduler
  import accel_pkg::*;
#(
  parameter int DATA_W  = accel_pkg::DATA_W,
  parameter int DIVISOR = accel_pkg::DIVISOR,
  parameter int SAT_MAX = accel_pkg::SAT_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] data_x,
  input  logic [DATA_W-1:0] data_y,
  input  logic [DATA_W-1:0] data_z,
  output logic [7:0]        scaled_x,
  output logic [7:0]        scaled_y,
  output logic [7:0]        scaled_z,
  output logic [3:0]        tens_x,
  output logic [3:0]        tens_y,
  output logic [3:0]        tens_z,
  output logic [3:0]        ones_x,
  output logic [3:0]        ones_y,
  output logic [3:0]        ones_z,
  output logic              neg_x,
  output logic              neg_y,
  output logic              neg_z,
  output logic              sat_x,
  output logic              sat_y,
  output logic              sat_z,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int CW = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  axis_e             axis_q, axis_d;
  logic [4:0]        cyc_q, cyc_d;
  logic [DATA_W-1:0] snap_x_q, snap_x_d;
  logic [DATA_W-1:0] snap_y_q, snap_y_d;
  logic [DATA_W-1:0] snap_z_q, snap_z_d;
  logic [DATA_W-1:0] abs_q, abs_d;
  logic              neg_q, neg_d;
  logic [7:0]        q_q, q_d;
  logic              sat_q, sat_d;
  digits_t [2:0]     shadow_q, shadow_d;
  digits_t [2:0]     res_q, res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;

  logic              div_start;
  logic [CW-1:0]     div_nbits;
  logic [DATA_W-1:0] div_dividend;
  logic [DATA_W-1:0] div_divisor;
  logic [DATA_W-1:0] div_quotient;
  logic [DATA_W-1:0] div_remainder;
  logic              div_valid;

  logic [DATA_W-1:0] sel;
  logic              q_clip;
  logic [7:0]        q_val;
  logic              div_unused;

  seq_divider #(.WIDTH(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .nbits     (div_nbits),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quotient),
    .remainder (div_remainder),
    .valid     (div_valid)
  );

  // Only the low digit of the second-stage remainder is meaningful.
  assign div_unused = ^div_remainder[DATA_W-1:4];

  // Next-state, datapath and divider control.
  always_comb begin
    state_d   = state_q;
    axis_d    = axis_q;
    cyc_d     = cyc_q;
    snap_x_d  = snap_x_q;
    snap_y_d  = snap_y_q;
    snap_z_d  = snap_z_q;
    abs_d     = abs_q;
    neg_d     = neg_q;
    q_d       = q_q;
    sat_d     = sat_q;
    shadow_d  = shadow_q;
    res_d     = res_q;
    done_d    = 1'b0;
    // busy_q also covers the done cycle, so it is the "ignore request" flag.
    overrun_d = sample_valid && busy_q;

    div_start    = 1'b0;
    div_nbits    = CW'(DIV1_CYCLES);
    div_dividend = abs_q;
    div_divisor  = DATA_W'(DIVISOR);

    case (axis_q)
      AX_X:    sel = snap_x_q;
      AX_Y:    sel = snap_y_q;
      AX_Z:    sel = snap_z_q;
      default: sel = snap_x_q;
    endcase

    q_clip = (div_quotient > DATA_W'(SAT_MAX));
    q_val  = q_clip ? 8'(SAT_MAX) : div_quotient[7:0];

    case (state_q)
      ST_IDLE: begin
        if (sample_valid && !busy_q) begin
          snap_x_d = data_x;
          snap_y_d = data_y;
          snap_z_d = data_z;
          axis_d   = AX_X;
          state_d  = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // -32768 maps to 32768, which still fits unsigned in DATA_W bits.
        neg_d   = sel[DATA_W-1];
        abs_d   = sel[DATA_W-1] ? (~sel + DATA_W'(1)) : sel;
        cyc_d   = 5'd0;
        state_d = ST_DIV1;
      end
      ST_DIV1: begin
        div_start = (cyc_q == 5'd0);
        if (cyc_q == 5'(DIV1_CYCLES - 1)) begin
          cyc_d   = 5'd0;
          state_d = ST_DIV2;
        end else begin
          cyc_d = cyc_q + 5'd1;
        end
      end
      ST_DIV2: begin
        // First cycle: scale result just landed; clip it and start q/10,
        // left-aligned so an 8-iteration run sees all of q.
        div_nbits    = CW'(DIV2_CYCLES);
        div_dividend = {q_val, {(DATA_W-8){1'b0}}};
        div_divisor  = DATA_W'(10);
        if (div_valid) begin
          div_start = 1'b1;
          q_d       = q_val;
          sat_d     = q_clip;
        end else begin
          div_start = 1'b0;
        end
        if (cyc_q == 5'(DIV2_CYCLES - 1)) begin
          cyc_d   = 5'd0;
          state_d = ST_STORE;
        end else begin
          cyc_d = cyc_q + 5'd1;
        end
      end
      ST_STORE: begin
        shadow_d[axis_q] = '{scaled: q_q,
                             tens:   div_quotient[3:0],
                             ones:   div_remainder[3:0],
                             neg:    neg_q,
                             sat:    sat_q};
        case (axis_q)
          AX_X:    begin axis_d = AX_Y; state_d = ST_LOAD;   end
          AX_Y:    begin axis_d = AX_Z; state_d = ST_LOAD;   end
          AX_Z:    begin axis_d = AX_X; state_d = ST_COMMIT; end
          default: begin axis_d = AX_X; state_d = ST_IDLE;   end
        endcase
      end
      ST_COMMIT: begin
        res_d   = shadow_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE) || (state_q == ST_COMMIT);
  end

  // Scheduler state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      axis_q    <= AX_X;
      cyc_q     <= 5'd0;
      snap_x_q  <= {DATA_W{1'b0}};
      snap_y_q  <= {DATA_W{1'b0}};
      snap_z_q  <= {DATA_W{1'b0}};
      abs_q     <= {DATA_W{1'b0}};
      neg_q     <= 1'b0;
      q_q       <= 8'd0;
      sat_q     <= 1'b0;
      shadow_q  <= '0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      axis_q    <= axis_d;
      cyc_q     <= cyc_d;
      snap_x_q  <= snap_x_d;
      snap_y_q  <= snap_y_d;
      snap_z_q  <= snap_z_d;
      abs_q     <= abs_d;
      neg_q     <= neg_d;
      q_q       <= q_d;
      sat_q     <= sat_d;
      shadow_q  <= shadow_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign scaled_x = res_q[0].scaled;
  assign scaled_y = res_q[1].scaled;
  assign scaled_z = res_q[2].scaled;
  assign tens_x   = res_q[0].tens;
  assign tens_y   = res_q[1].tens;
  assign tens_z   = res_q[2].tens;
  assign ones_x   = res_q[0].ones;
  assign ones_y   = res_q[1].ones;
  assign ones_z   = res_q[2].ones;
  assign neg_x    = res_q[0].neg;
  assign neg_y    = res_q[1].neg;
  assign neg_z    = res_q[2].neg;
  assign sat_x    = res_q[0].sat;
  assign sat_y    = res_q[1].sat;
  assign sat_z    = res_q[2].sat;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_axis_digit_scheduler.sv
// Self-checking bench for axis_digit_scheduler: directed and random samples
// compared against an arithmetic model of the digit rules.
module tb_axis_digit_scheduler;

  logic        clk;
  logic        rst;
  logic        sample_valid;
  logic [15:0] data_x, data_y, data_z;
  logic [7:0]  scaled_x, scaled_y, scaled_z;
  logic [3:0]  tens_x, tens_y, tens_z;
  logic [3:0]  ones_x, ones_y, ones_z;
  logic        neg_x, neg_y, neg_z;
  logic        sat_x, sat_y, sat_z;
  logic        busy, done, overrun;

  int checks = 0;
  int errors = 0;
  int prev_scaled_x = 0;

  axis_digit_scheduler dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .data_x(data_x), .data_y(data_y), .data_z(data_z),
    .scaled_x(scaled_x), .scaled_y(scaled_y), .scaled_z(scaled_z),
    .tens_x(tens_x), .tens_y(tens_y), .tens_z(tens_z),
    .ones_x(ones_x), .ones_y(ones_y), .ones_z(ones_z),
    .neg_x(neg_x), .neg_y(neg_y), .neg_z(neg_z),
    .sat_x(sat_x), .sat_y(sat_y), .sat_z(sat_z),
    .busy(busy), .done(done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference rules: |v|, divide by 10, clip at 99, split into digits.
  function automatic int ref_abs(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  function automatic int ref_scaled(input logic [15:0] v);
    int q;
    q = ref_abs(v) / 10;
    return (q > 99) ? 99 : q;
  endfunction

  task automatic check_axis(input string ax, input logic [15:0] v,
                            input logic [7:0] sc, input logic [3:0] t,
                            input logic [3:0] o, input logic n, input logic s);
    int q;
    q = ref_scaled(v);
    chk({ax, "_scaled"}, 32'(sc), 32'(q));
    chk({ax, "_tens"},   32'(t),  32'(q / 10));
    chk({ax, "_ones"},   32'(o),  32'(q % 10));
    chk({ax, "_neg"},    32'(n),  32'($signed(v) < 0));
    chk({ax, "_sat"},    32'(s),  32'((ref_abs(v) / 10) > 99));
  endtask

  function automatic logic any_output();
    return |{scaled_x, scaled_y, scaled_z, tens_x, tens_y, tens_z,
             ones_x, ones_y, ones_z, neg_x, neg_y, neg_z,
             sat_x, sat_y, sat_z, busy, done, overrun};
  endfunction

  // Accept one sample and follow it to its commit.
  task automatic run_sample(input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] z, input bit ovr_test,
                            input bit scramble);
    int done_at, done_cnt, busy_gaps, ovr_cnt;
    done_at = -1; done_cnt = 0; busy_gaps = 0; ovr_cnt = 0;
    data_x = x; data_y = y; data_z = z;
    sample_valid = 1'b1;
    tick();
    for (int i = 1; i <= 85; i++) begin
      sample_valid = ovr_test && (i == 10 || i == 80);
      if (scramble || ovr_test) begin
        data_x = 16'($urandom);
        data_y = 16'($urandom);
        data_z = 16'($urandom);
      end
      tick();
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (overrun) ovr_cnt++;
      if (i <= 79 && !busy) busy_gaps++;
      if (i == 78) chk("hold_before_commit", 32'(scaled_x), 32'(prev_scaled_x));
      if (i == 79) begin
        check_axis("x", x, scaled_x, tens_x, ones_x, neg_x, sat_x);
        check_axis("y", y, scaled_y, tens_y, ones_y, neg_y, sat_y);
        check_axis("z", z, scaled_z, tens_z, ones_z, neg_z, sat_z);
      end
      if (i == 80) chk("busy_after_done", 32'(busy), 32'd0);
    end
    sample_valid = 1'b0;
    chk("done_latency", 32'(done_at), 32'd79);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("busy_gaps", 32'(busy_gaps), 32'd0);
    chk("overrun_pulses", 32'(ovr_cnt), ovr_test ? 32'd2 : 32'd0);
    chk("hold_after_commit", 32'(scaled_x), 32'(ref_scaled(x)));
    prev_scaled_x = ref_scaled(x);
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1;
    sample_valid = 1'b0;
    data_x = 16'd0; data_y = 16'd0; data_z = 16'd0;
    repeat (3) tick();
    chk("reset_outputs", 32'(any_output()), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    run_sample(16'h00B4, 16'hFF4C, 16'h0009, 1'b0, 1'b0);
    run_sample(16'h03E7, 16'(($urandom_range(0, 2000))), 16'h8000, 1'b0, 1'b0);
    run_sample(16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0);
    run_sample(16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b1);

    // Abort mid-operation with reset.
    data_x = 16'h1234; data_y = 16'hF000; data_z = 16'h0400;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (39) tick();
    rst = 1'b1;
    #1;
    chk("abort_outputs", 32'(any_output()), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 90; i++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    prev_scaled_x = 0;

    run_sample(16'd50, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run_sample(16'hFFF9, 16'h0000, 16'h0000, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      case (k)
        0:       run_sample(16'h7FFF, 16'h8001, 16'hFC19, 1'b0, 1'b0);
        1:       run_sample(16'h03E8, 16'hFC18, 16'h03DE, 1'b0, 1'b0);
        default: run_sample(16'($urandom), 16'($urandom_range(0, 1200)),
                            16'($urandom), 1'b0, 1'b0);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
